// File: rtl/flash_command_sequencer_if.sv
// Command-side handshake between the CPU flash-access datapath and the
// flash command sequencer.
interface flash_command_sequencer_if;
    logic        CMD_VALID;
    logic [1:0]  CMD_OP;
    logic [18:0] CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        CMD_READY;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    modport master (
        output CMD_VALID,
        output CMD_OP,
        output CMD_ADDR,
        output CMD_DATA,
        input  CMD_READY,
        input  BUSY,
        input  DONE,
        input  ERR
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_OP,
        input  CMD_ADDR,
        input  CMD_DATA,
        output CMD_READY,
        output BUSY,
        output DONE,
        output ERR
    );
endinterface

// File: rtl/flash_command_sequencer.sv
// JEDEC command sequencer for the x16 Kickstart flash: unlock/program/erase
// write cycles, DQ6 toggle polling, and F0 recovery on failure.
module flash_command_sequencer #(
    parameter int unsigned WE_CYCLES  = 4,
    parameter int unsigned RD_CYCLES  = 3,
    parameter logic [19:0] POLL_LIMIT = 20'hFFFFF
) (
    input  logic                            CLK,
    input  logic                            RESET,
    flash_command_sequencer_if.slave        cmd,
    output logic [18:0]                     FLASH_ADDR,
    output logic [15:0]                     FLASH_DQ_OUT,
    input  logic [15:0]                     FLASH_DQ_IN,
    output logic                            FLASH_DQ_OE,
    output logic [1:0]                      FLASH_WR_n,
    output logic [1:0]                      FLASH_RD_n
);

    localparam logic [1:0] OP_PROG   = 2'b00;
    localparam logic [1:0] OP_SERASE = 2'b01;
    localparam logic [1:0] OP_CERASE = 2'b10;
    localparam logic [1:0] OP_RESET  = 2'b11;

    localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);
    localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_LOW,
        S_W_HOLD,
        S_R_LOW,
        S_R_GAP,
        S_FINISH
    } state_e;

    typedef enum logic [1:0] {
        PR_AGAIN,
        PR_DONE,
        PR_ABORT
    } poll_res_e;

    state_e      state_q, state_d;
    poll_res_e   res_q, res_d;
    logic [1:0]  op_q, op_d;
    logic [18:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [2:0]  step_q, step_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] poll_cnt_q, poll_cnt_d;
    logic        dq6_q, dq6_d;
    logic        abort_q, abort_d;

    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [18:0] faddr_q, faddr_d;
    logic [15:0] fdq_q, fdq_d;
    logic        oe_q, oe_d;
    logic [1:0]  wr_n_q, wr_n_d;
    logic [1:0]  rd_n_q, rd_n_d;

    logic        accept;
    logic [19:0] poll_inc;
    logic [34:0] wr_entry;
    logic [18:0] poll_addr;
    logic        unused_dq;

    assign unused_dq = ^{FLASH_DQ_IN[15:7], FLASH_DQ_IN[4:0]};

    function automatic logic [34:0] seq_entry(
        input logic [1:0]  op,
        input logic [2:0]  step,
        input logic [18:0] a,
        input logic [15:0] d
    );
        logic [34:0] e;
        e = {19'h00000, 16'h00F0};
        unique case (op)
            OP_PROG: begin
                case (step)
                    3'd0:    e = {19'h00555, 16'h00AA};
                    3'd1:    e = {19'h002AA, 16'h0055};
                    3'd2:    e = {19'h00555, 16'h00A0};
                    default: e = {a, d};
                endcase
            end
            OP_SERASE, OP_CERASE: begin
                case (step)
                    3'd0, 3'd3: e = {19'h00555, 16'h00AA};
                    3'd1, 3'd4: e = {19'h002AA, 16'h0055};
                    3'd2:       e = {19'h00555, 16'h0080};
                    default: begin
                        if (op == OP_SERASE) e = {a, 16'h0030};
                        else                 e = {19'h00555, 16'h0010};
                    end
                endcase
            end
            default: e = {19'h00000, 16'h00F0};
        endcase
        return e;
    endfunction

    function automatic logic [2:0] last_step(input logic [1:0] op);
        logic [2:0] s;
        unique case (op)
            OP_PROG:              s = 3'd3;
            OP_SERASE, OP_CERASE: s = 3'd5;
            default:              s = 3'd0;
        endcase
        return s;
    endfunction

    assign accept = cmd.CMD_VALID && ready_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            res_q      <= PR_AGAIN;
            op_q       <= 2'b00;
            addr_q     <= '0;
            data_q     <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
            poll_cnt_q <= '0;
            dq6_q      <= 1'b0;
            abort_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            faddr_q    <= '0;
            fdq_q      <= '0;
            oe_q       <= 1'b0;
            wr_n_q     <= 2'b11;
            rd_n_q     <= 2'b11;
        end else begin
            state_q    <= state_d;
            res_q      <= res_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            poll_cnt_q <= poll_cnt_d;
            dq6_q      <= dq6_d;
            abort_q    <= abort_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            faddr_q    <= faddr_d;
            fdq_q      <= fdq_d;
            oe_q       <= oe_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        poll_cnt_d = poll_cnt_q;
        dq6_d      = dq6_q;
        abort_d    = abort_q;
        poll_inc   = poll_cnt_q + 20'd1;

        unique case (state_q)
            S_IDLE, S_FINISH: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d       = cmd.CMD_OP;
                    addr_d     = cmd.CMD_ADDR;
                    data_d     = cmd.CMD_DATA;
                    step_d     = '0;
                    poll_cnt_d = '0;
                    abort_d    = 1'b0;
                    state_d    = S_W_SETUP;
                end
            end
            S_W_SETUP: begin
                cnt_d   = '0;
                state_d = S_W_LOW;
            end
            S_W_LOW: begin
                if (cnt_q == WE_LAST) state_d = S_W_HOLD;
                else                  cnt_d   = cnt_q + 4'd1;
            end
            S_W_HOLD: begin
                if (abort_q) begin
                    state_d = S_FINISH;
                end else if (step_q == last_step(op_q)) begin
                    cnt_d   = '0;
                    state_d = (op_q == OP_RESET) ? S_FINISH : S_R_LOW;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = S_W_SETUP;
                end
            end
            S_R_LOW: begin
                if (cnt_q == RD_LAST) begin
                    state_d = S_R_GAP;
                    // First read only seeds DQ6; a match needs two reads.
                    if (poll_cnt_q == '0 ||
                        (FLASH_DQ_IN[6] != dq6_q && !FLASH_DQ_IN[5])) begin
                        dq6_d      = FLASH_DQ_IN[6];
                        poll_cnt_d = poll_inc;
                        res_d      = (poll_inc == POLL_LIMIT) ? PR_ABORT
                                                              : PR_AGAIN;
                    end else if (FLASH_DQ_IN[6] == dq6_q) begin
                        res_d = PR_DONE;
                    end else begin
                        res_d = PR_ABORT;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_R_GAP: begin
                cnt_d = '0;
                unique case (res_q)
                    PR_DONE:  state_d = S_FINISH;
                    PR_ABORT: begin
                        abort_d = 1'b1;
                        state_d = S_W_SETUP;
                    end
                    default:  state_d = S_R_LOW;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_entry  = abort_d ? {19'h00000, 16'h00F0}
                               : seq_entry(op_d, step_d, addr_d, data_d);
    assign poll_addr = (op_d == OP_CERASE) ? 19'h00000 : addr_d;

    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = err_q;
        faddr_d = '0;
        fdq_d   = '0;
        oe_d    = 1'b0;
        wr_n_d  = 2'b11;
        rd_n_d  = 2'b11;

        unique case (state_d)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            S_FINISH: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = abort_d;
            end
            S_W_SETUP, S_W_HOLD: begin
                faddr_d = wr_entry[34:16];
                fdq_d   = wr_entry[15:0];
                oe_d    = 1'b1;
            end
            S_W_LOW: begin
                faddr_d = wr_entry[34:16];
                fdq_d   = wr_entry[15:0];
                oe_d    = 1'b1;
                wr_n_d  = 2'b00;
            end
            S_R_LOW: begin
                faddr_d = poll_addr;
                rd_n_d  = 2'b00;
            end
            S_R_GAP: begin
                faddr_d = poll_addr;
            end
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (accept) err_d = 1'b0;
    end

    assign cmd.CMD_READY = ready_q;
    assign cmd.BUSY      = busy_q;
    assign cmd.DONE      = done_q;
    assign cmd.ERR       = err_q;
    assign FLASH_ADDR    = faddr_q;
    assign FLASH_DQ_OUT  = fdq_q;
    assign FLASH_DQ_OE   = oe_q;
    assign FLASH_WR_n    = wr_n_q;
    assign FLASH_RD_n    = rd_n_q;

endmodule

// File: tb/tb_flash_command_sequencer.sv
// Bench for flash_command_sequencer: a DQ6/DQ5 flash model on the pins and
// a closed-form expectation of write cycles, poll reads and ERR.
module tb_flash_command_sequencer;

    localparam int WE  = 4;
    localparam int RD  = 3;
    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [18:0] faddr;
    logic [15:0] fdq_out;
    logic [15:0] fdq_in;
    logic        oe;
    logic [1:0]  wr_n;
    logic [1:0]  rd_n;

    int tests = 0;
    int fails = 0;

    int toggles = 0;
    int dq5_at  = 0;

    int reads    = 0;
    int wlow     = 0;
    int rlow     = 0;
    int done_cnt = 0;
    int viol     = 0;

    logic [34:0] wq[$];
    int          wlq[$];
    logic [18:0] rq[$];
    int          rlq[$];
    logic [34:0] expq[$];
    logic [18:0] wa_m;
    logic [15:0] wd_m;
    logic [18:0] ra_m;

    flash_command_sequencer_if cif();

    flash_command_sequencer #(
        .WE_CYCLES (WE),
        .RD_CYCLES (RD),
        .POLL_LIMIT(20'd8)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .cmd         (cif),
        .FLASH_ADDR  (faddr),
        .FLASH_DQ_OUT(fdq_out),
        .FLASH_DQ_IN (fdq_in),
        .FLASH_DQ_OE (oe),
        .FLASH_WR_n  (wr_n),
        .FLASH_RD_n  (rd_n)
    );

    always #5 clk = ~clk;

    // Status word returned by read k: DQ6 toggles on the first tog+1
    // reads, then freezes; DQ5 rises from read d5 on.
    function automatic logic [15:0] flash_status(input int k, input int tog,
                                                 input int d5);
        logic [15:0] v;
        int ph;
        v = 16'hA500 | 16'(k & 15);
        ph = (k <= tog + 1) ? k : tog + 1;
        v[6] = (ph % 2) == 1;
        v[5] = (d5 != 0) && (k >= d5);
        return v;
    endfunction

    always @* fdq_in = flash_status(reads + 1, toggles, dq5_at);

    always @(negedge clk) begin
        if (wr_n == 2'b00) begin
            wlow++;
            wa_m = faddr;
            wd_m = fdq_out;
            if (oe !== 1'b1 || rd_n !== 2'b11) viol++;
        end else if (wlow > 0) begin
            wq.push_back({wa_m, wd_m});
            wlq.push_back(wlow);
            wlow = 0;
        end
        if (rd_n == 2'b00) begin
            rlow++;
            ra_m = faddr;
            if (oe !== 1'b0) viol++;
        end else if (rlow > 0) begin
            rq.push_back(ra_m);
            rlq.push_back(rlow);
            reads++;
            rlow = 0;
        end
        if (wr_n[0] !== wr_n[1] || rd_n[0] !== rd_n[1]) viol++;
        if (cif.DONE === 1'b1) done_cnt++;
    end

    task automatic clear_mon();
        reads    = 0;
        wlow     = 0;
        rlow     = 0;
        done_cnt = 0;
        viol     = 0;
        wq.delete();
        wlq.delete();
        rq.delete();
        rlq.delete();
    endtask

    task automatic build_expected(input logic [1:0] op, input logic [18:0] a,
                                  input logic [15:0] d, input bit ab);
        expq.delete();
        case (op)
            2'b00: begin
                expq.push_back({19'h00555, 16'h00AA});
                expq.push_back({19'h002AA, 16'h0055});
                expq.push_back({19'h00555, 16'h00A0});
                expq.push_back({a, d});
            end
            2'b01, 2'b10: begin
                expq.push_back({19'h00555, 16'h00AA});
                expq.push_back({19'h002AA, 16'h0055});
                expq.push_back({19'h00555, 16'h0080});
                expq.push_back({19'h00555, 16'h00AA});
                expq.push_back({19'h002AA, 16'h0055});
                if (op == 2'b01) expq.push_back({a, 16'h0030});
                else             expq.push_back({19'h00555, 16'h0010});
            end
            default: expq.push_back({19'h00000, 16'h00F0});
        endcase
        if (ab) expq.push_back({19'h00000, 16'h00F0});
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op,
                           input logic [18:0] a, input logic [15:0] d,
                           input int tog, input int d5, input int hold);
        int nm;
        int nd;
        int n_exp;
        bit ab;
        bit got;
        logic [18:0] pa;
        toggles = tog;
        dq5_at  = d5;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (cif.CMD_READY === 1'b1) begin
                got = 1;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s ready_wait: CMD_READY got 0 required 1", name);
        end
        clear_mon();
        cif.CMD_VALID = 1'b1;
        cif.CMD_OP    = op;
        cif.CMD_ADDR  = a;
        cif.CMD_DATA  = d;
        @(posedge clk); #1;
        tests++;
        if ({cif.BUSY, cif.CMD_READY} !== 2'b10) begin
            fails++;
            $display("FAIL %s accept: BUSY,READY got %b required 10", name,
                     {cif.BUSY, cif.CMD_READY});
        end
        if (hold > 0) begin
            cif.CMD_OP   = ~op;
            cif.CMD_ADDR = ~a;
            repeat (hold) @(posedge clk);
            #1;
        end
        cif.CMD_VALID = 1'b0;

        // Reads to resolution: match at tog+2, DQ5 abort no earlier than read 2.
        nm = tog + 2;
        nd = (d5 == 0) ? 32'h3FFFFFFF : ((d5 < 2) ? 2 : d5);
        if (op == 2'b11) begin
            n_exp = 0;
            ab    = 0;
        end else begin
            if (nd < nm) begin
                n_exp = nd;
                ab    = 1;
            end else begin
                n_exp = nm;
                ab    = 0;
            end
            if (n_exp > LIM) begin
                n_exp = LIM;
                ab    = 1;
            end
        end
        build_expected(op, a, d, ab);
        pa = (op == 2'b10) ? 19'h00000 : a;

        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (cif.DONE === 1'b1) begin
                got = 1;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s done_timeout: DONE got 0 required 1", name);
        end
        tests++;
        if ({cif.ERR, cif.CMD_READY, cif.BUSY} !== {ab, 2'b10}) begin
            fails++;
            $display("FAIL %s finish: ERR,READY,BUSY got %b required %b",
                     name, {cif.ERR, cif.CMD_READY, cif.BUSY}, {ab, 2'b10});
        end
        @(posedge clk); #2;
        tests++;
        if ({cif.DONE, cif.ERR} !== {1'b0, ab}) begin
            fails++;
            $display("FAIL %s after_done: DONE,ERR got %b required %b", name,
                     {cif.DONE, cif.ERR}, {1'b0, ab});
        end
        @(negedge clk); #1;

        tests++;
        if (wq.size() != expq.size()) begin
            fails++;
            $display("FAIL %s write_count: got %0d required %0d", name,
                     wq.size(), expq.size());
        end
        for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
            tests++;
            if (wq[i] !== expq[i] || wlq[i] != WE) begin
                fails++;
                $display("FAIL %s write%0d: got %h/%h low=%0d required %h/%h low=%0d",
                         name, i, wq[i][34:16], wq[i][15:0], wlq[i],
                         expq[i][34:16], expq[i][15:0], WE);
            end
        end
        tests++;
        if (reads != n_exp) begin
            fails++;
            $display("FAIL %s poll_reads: got %0d required %0d", name, reads,
                     n_exp);
        end
        for (int i = 0; i < rq.size(); i++) begin
            tests++;
            if (rq[i] !== pa || rlq[i] != RD) begin
                fails++;
                $display("FAIL %s read%0d: got addr %h low=%0d required %h low=%0d",
                         name, i, rq[i], rlq[i], pa, RD);
            end
        end
        tests++;
        if (done_cnt != 1 || viol != 0) begin
            fails++;
            $display("FAIL %s pulses: done=%0d viol=%0d required 1/0", name,
                     done_cnt, viol);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({cif.CMD_READY, cif.BUSY, cif.DONE, cif.ERR} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_status: got %b required 1000",
                     {cif.CMD_READY, cif.BUSY, cif.DONE, cif.ERR});
        end
        tests++;
        if ({wr_n, rd_n, oe, faddr, fdq_out} !== {4'b1111, 1'b0, 35'h0}) begin
            fails++;
            $display("FAIL reset_pins: got wr=%b rd=%b oe=%b a=%h d=%h required 11 11 0 0 0",
                     wr_n, rd_n, oe, faddr, fdq_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_program();
        run_cmd("program", 2'b00, 19'h12345, 16'hBEEF, 3, 0, 0);
    endtask

    task automatic test_sector_erase();
        run_cmd("sector_erase", 2'b01, 19'h40000, 16'h1234,
                int'($urandom_range(0, 5)), 0, 0);
    endtask

    task automatic test_chip_erase_abort();
        run_cmd("chip_erase_dq5", 2'b10, 19'h7ABCD, 16'h0000, 5, 2, 0);
    endtask

    task automatic test_poll_timeout();
        run_cmd("poll_timeout", 2'b01, 19'h1F000, 16'h0000, 100, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_cmd("reset_op_busy", 2'b11, 19'h55555, 16'h9999, 0, 0, 3);
        repeat (20) @(posedge clk);
        #1;
        tests++;
        if (done_cnt != 1 || wq.size() != 1) begin
            fails++;
            $display("FAIL busy_ignore: done=%0d writes=%0d required 1/1",
                     done_cnt, wq.size());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_cmd($sformatf("random%0d", n), 2'($urandom_range(0, 3)),
                    19'($urandom), 16'($urandom), int'($urandom_range(0, 9)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0,
                    0);
        end
    endtask

    task automatic test_mid_reset();
        bit got;
        toggles = 50;
        dq5_at  = 0;
        @(posedge clk); #1;
        clear_mon();
        cif.CMD_VALID = 1'b1;
        cif.CMD_OP    = 2'b00;
        cif.CMD_ADDR  = 19'h0ABCD;
        cif.CMD_DATA  = 16'h5A5A;
        @(posedge clk); #1;
        cif.CMD_VALID = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (wq.size() == 2 && wr_n == 2'b00) begin
                got = 1;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL mid_reset_wait: third write low not seen");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({wr_n, oe, cif.CMD_READY, cif.BUSY, cif.DONE} !== 6'b110100) begin
            fails++;
            $display("FAIL mid_reset: wr,oe,ready,busy,done got %b required 110100",
                     {wr_n, oe, cif.CMD_READY, cif.BUSY, cif.DONE});
        end
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if (done_cnt != 0 || cif.BUSY !== 1'b0 || cif.ERR !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_after: done=%0d busy=%b err=%b required 0/0/0",
                     done_cnt, cif.BUSY, cif.ERR);
        end
    endtask

    initial begin
        cif.CMD_VALID = 1'b0;
        cif.CMD_OP    = 2'b00;
        cif.CMD_ADDR  = '0;
        cif.CMD_DATA  = '0;
        test_reset();
        test_program();
        test_sector_erase();
        test_chip_erase_abort();
        test_back_to_back();
        test_random();
        test_poll_timeout();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flash_command_sequencer.md
Name: flash_command_sequencer

Overview:
- Sequences JEDEC command cycles (unlock, program, sector/chip erase, read-array reset) onto the x16 Kickstart flash.
- Polls completion using the DQ6 toggle bit and reports the result.
- Sits between the flash-access datapath (bus decode and FLASH_RD_n/FLASH_WR_n steering) and the flash pins, so the CPU can program the flash with single requests and no per-cycle bus timing.
- Owns the flash pins while BUSY=1; the datapath muxes them back when BUSY=0.

Parameters:
WE_CYCLES, 4, clocks FLASH_WR_n is held low per write cycle (1..15)
RD_CYCLES, 3, clocks FLASH_RD_n is held low per poll read; DQ is sampled on the last of them (1..15)
POLL_LIMIT, 20'hFFFFF, maximum poll reads before timeout

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous active-high reset
CMD_VALID  in  1  request strobe; accepted when CMD_VALID && CMD_READY
CMD_OP  in  2  00 program word, 01 sector erase, 10 chip erase, 11 read-array reset
CMD_ADDR  in  19  word address (program target or sector address)
CMD_DATA  in  16  program data
CMD_READY  out  1  idle, able to accept a request
BUSY  out  1  sequence in progress
DONE  out  1  one-clock completion pulse
ERR  out  1  valid with DONE: 1 = timeout or DQ5 failure
FLASH_ADDR  out  19  flash word address
FLASH_DQ_OUT  out  16  write data
FLASH_DQ_IN  in  16  read data
FLASH_DQ_OE  out  1  drive DQ
FLASH_WR_n  out  2  {upper,lower} write enables, always driven equal
FLASH_RD_n  out  2  {upper,lower} output enables, always driven equal

Behaviour:
Reset and idle:
- All outputs are registered.
- Under RESET (takes effect at the next edge, including mid-sequence): state IDLE, CMD_READY=1, BUSY=0, DONE=0, ERR=0, FLASH_WR_n=2'b11, FLASH_RD_n=2'b11, FLASH_DQ_OE=0, FLASH_ADDR=0, FLASH_DQ_OUT=0.
- A reset mid-sequence aborts immediately; no F0 recovery cycle is issued.
- In IDLE the flash pins hold their reset values.

Accept:
- CMD_VALID && CMD_READY at an edge captures OP, ADDR and DATA.
- On that edge: CMD_READY=0, BUSY=1.
- CMD_VALID while busy is ignored (no queueing).

Write cycle (W_SETUP, W_LOW, W_HOLD):
- W_SETUP, 1 clock: ADDR/DQ_OUT valid, DQ_OE=1, WR_n=11.
- W_LOW, WE_CYCLES clocks: WR_n=00.
- W_HOLD, 1 clock: WR_n=11, ADDR/DATA still valid.
- Total per write: WE_CYCLES+2 clocks. RD_n stays 11 throughout.

Sequence tables ({addr,data}):
- Program: {555,AA} {2AA,55} {555,A0} {ADDR,DATA} -> POLL
- Sector erase: {555,AA} {2AA,55} {555,80} {555,AA} {2AA,55} {ADDR,0030} -> POLL
- Chip erase: the sector-erase sequence with the last cycle {555,0010} -> POLL
- Reset: {000,00F0} -> FINISH (ERR=0)
- A 3-bit step index walks the table.

Poll read (R_LOW, R_GAP):
- R_LOW, RD_CYCLES clocks: DQ_OE=0, RD_n=00, ADDR=captured ADDR (000 for chip erase). FLASH_DQ_IN is sampled at the final R_LOW edge.
- R_GAP, 1 clock: RD_n=11.
- The first read only stores DQ6 and increments the poll counter.
- Each subsequent read compares DQ6 with the stored value:
  - equal -> FINISH, ERR=0
  - differ and DQ5=1 -> ABORT
  - differ and DQ5=0 -> store DQ6, increment counter, read again
- Counter is 20 bits, cleared at accept. Reaching POLL_LIMIT reads without a match -> ABORT; no wrap-around is possible.

ABORT:
- Issues one write cycle {000,00F0}, then FINISH with ERR=1.

FINISH:
- 1 clock: DONE=1, ERR set as above, BUSY=0, CMD_READY=1.
- ERR holds until the next accept; DONE clears on the next clock.
- A new request may be accepted in the cycle after DONE.

Test Plan:
- Reset, then program ADDR=0x12345 DATA=0xBEEF (WE_CYCLES=4) with a flash model whose DQ6 toggles 3 reads then is stable -> write cycles {555,AA}{2AA,55}{555,A0}{12345,BEEF}, each with 4 clocks WR_n=00; 5 poll reads; DONE pulse, ERR=0.
- Sector erase ADDR=0x40000 -> six write cycles ending {40000,0030}; polls at 0x40000; DONE with ERR=0 once DQ6 is stable.
- Chip erase with DQ6 toggling and DQ5=1 on the 2nd read -> ABORT write {000,00F0}, DONE with ERR=1.
- POLL_LIMIT=8 with DQ6 toggling forever and DQ5=0 -> exactly 8 poll reads, then F0 cycle, ERR=1.
- Reset op -> single {000,00F0} write, no reads, DONE with ERR=0; CMD_VALID asserted during BUSY is ignored (exactly one DONE).
- RESET asserted during W_LOW of the 3rd program cycle -> next edge: WR_n=11, DQ_OE=0, CMD_READY=1, no DONE pulse.
